// File: rtl/store_fwd_if.sv
// Store/load/memory bus of the store-to-load forwarding buffer.
// The pipeline side drives through master; the buffer attaches as slave.
interface store_fwd_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  localparam int NB = DW / 8;

  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_wdata;
  logic [NB-1:0] st_be;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] ld_data;
  logic          ld_data_valid;
  logic          fwd_hit;

  modport master (
    output st_valid, st_addr, st_wdata, st_be, ld_valid, ld_addr, mem_rdata,
    input  ld_data, ld_data_valid, fwd_hit
  );

  modport slave (
    input  st_valid, st_addr, st_wdata, st_be, ld_valid, ld_addr, mem_rdata,
    output ld_data, ld_data_valid, fwd_hit
  );
endinterface

// File: rtl/store_fwd_buffer.sv
// Store-to-load forwarding buffer: ring of the last DEPTH stores, each forwardable for LIFETIME run-cycles.
// Define STORE_FWD_STATS_EN to add saturating stat_hits / stat_overwrites counters.
module store_fwd_buffer #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int DEPTH    = 4,
  parameter int LIFETIME = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         flush,
  store_fwd_if.slave                   bus,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef STORE_FWD_STATS_EN
  ,
  output logic [31:0]                  stat_hits,
  output logic [31:0]                  stat_overwrites
`endif
);
  localparam int NB  = DW / 8;
  localparam int OFS = $clog2(NB);
  localparam int WAW = AW - OFS;
  localparam int IW  = $clog2(DEPTH);
  localparam int OW  = $clog2(DEPTH + 1);
  // A one-cycle lifetime is covered entirely by the same-cycle bypass.
  localparam bit STORE_KEEP = (LIFETIME > 1);

  typedef struct packed {
    logic [WAW-1:0] waddr;
    logic [DW-1:0]  data;
    logic [NB-1:0]  be;
    logic [7:0]     age;
  } entry_t;

  entry_t           ent [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [IW-1:0]    head, tail;

  logic [NB-1:0]    mask_q;
  logic [DW-1:0]    data_q;
  logic             vld_q;

  logic             st_acc, st_wr, ld_acc, full, retire, overwrite;
  logic [7:0]       head_age_nxt;
  logic [WAW-1:0]   st_waddr, ld_waddr;
  logic [NB-1:0]    mask_d;
  logic [DW-1:0]    data_d;
  logic [IW-1:0]    idx;
  logic [DW-1:0]    ld_data_c;
  logic             unused_ofs;

  assign unused_ofs = ^{bus.st_addr[OFS-1:0], bus.ld_addr[OFS-1:0]};

  assign st_waddr     = bus.st_addr[AW-1:OFS];
  assign ld_waddr     = bus.ld_addr[AW-1:OFS];
  assign st_acc       = run & bus.st_valid & ~flush;
  assign st_wr        = st_acc & STORE_KEEP;
  assign ld_acc       = run & bus.ld_valid;
  assign full         = (occupancy == OW'(DEPTH));
  // Age counts run-cycles including the accept cycle, so an entry leaves after its (LIFETIME-1)th stored cycle.
  assign head_age_nxt = ent[head].age + 8'd1;
  assign retire       = run & ~flush & valid[head] & (head_age_nxt == 8'(LIFETIME));
  assign overwrite    = st_wr & full & ~retire;

  // Oldest-to-youngest scan so later matches override earlier ones per byte lane.
  always_comb begin
    // NOTE: every combinationally written variable gets a default first, otherwise a latch is inferred.
    mask_d = '0;
    data_d = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + IW'(i);
      for (int l = 0; l < NB; l++) begin
        if (valid[idx] && ent[idx].waddr == ld_waddr && ent[idx].be[l]) begin
          mask_d[l]          = 1'b1;
          data_d[l*8 +: 8]   = ent[idx].data[l*8 +: 8];
        end
      end
    end
    for (int l = 0; l < NB; l++) begin
      if (st_acc && st_waddr == ld_waddr && bus.st_be[l]) begin
        mask_d[l]        = 1'b1;
        data_d[l*8 +: 8] = bus.st_wdata[l*8 +: 8];
      end
    end
    if (!ld_acc) mask_d = '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated only with non-blocking assignments.
    if (!reset) begin
      valid     <= '0;
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      vld_q     <= 1'b0;
    end else begin
      vld_q  <= ld_acc;
      mask_q <= mask_d;
      data_q <= data_d;
      if (flush) begin
        valid     <= '0;
        head      <= '0;
        tail      <= '0;
        occupancy <= '0;
      end else if (run) begin
        if (retire) begin
          valid[head] <= 1'b0;
          head        <= head + IW'(1);
        end
        if (st_wr) begin
          valid[tail] <= 1'b1;
          tail        <= tail + IW'(1);
          if (overwrite) head <= head + IW'(1);
        end
        if (st_wr && !retire && !full)  occupancy <= occupancy + OW'(1);
        else if (retire && !st_wr)      occupancy <= occupancy - OW'(1);
      end
    end
  end

  // NOTE: the entry payload is deliberately not reset; the valid bits alone say what it holds.
  always_ff @(posedge clk) begin
    if (reset && run && !flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i].age <= ent[i].age + 8'd1;
      if (st_wr) ent[tail] <= '{waddr: st_waddr, data: bus.st_wdata, be: bus.st_be, age: 8'd1};
    end
  end

  always_comb begin
    ld_data_c = bus.mem_rdata;
    for (int l = 0; l < NB; l++)
      if (mask_q[l]) ld_data_c[l*8 +: 8] = data_q[l*8 +: 8];
  end

  assign bus.ld_data       = ld_data_c;
  assign bus.ld_data_valid = vld_q;
  assign bus.fwd_hit       = |mask_q;

`ifdef STORE_FWD_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_hits       <= '0;
      stat_overwrites <= '0;
    end else begin
      if (vld_q && |mask_q && stat_hits != '1) stat_hits <= stat_hits + 32'd1;
      if (overwrite && stat_overwrites != '1)  stat_overwrites <= stat_overwrites + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_store_fwd_buffer.sv
// Directed scoreboard bench: dut_a (DEPTH 4, LIFETIME 4) and dut_b (DEPTH 4, LIFETIME 8) share stimulus;
// the monitor compares load responses of the selected instance against queued expectations.
module tb_store_fwd_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, run, flush;
  logic        st_valid, ld_valid;
  logic [31:0] st_addr, st_wdata, ld_addr, mem_rdata;
  logic [3:0]  st_be;
  logic [2:0]  occ_a, occ_b;
`ifdef STORE_FWD_STATS_EN
  logic [31:0] hits_a, ovw_a, hits_b, ovw_b;
`endif

  store_fwd_if #(.AW(32), .DW(32)) if_a ();
  store_fwd_if #(.AW(32), .DW(32)) if_b ();

  assign if_a.st_valid  = st_valid;   assign if_b.st_valid  = st_valid;
  assign if_a.st_addr   = st_addr;    assign if_b.st_addr   = st_addr;
  assign if_a.st_wdata  = st_wdata;   assign if_b.st_wdata  = st_wdata;
  assign if_a.st_be     = st_be;      assign if_b.st_be     = st_be;
  assign if_a.ld_valid  = ld_valid;   assign if_b.ld_valid  = ld_valid;
  assign if_a.ld_addr   = ld_addr;    assign if_b.ld_addr   = ld_addr;
  assign if_a.mem_rdata = mem_rdata;  assign if_b.mem_rdata = mem_rdata;

  store_fwd_buffer #(.AW(32), .DW(32), .DEPTH(4), .LIFETIME(4)) dut_a (
    .clk(clk), .reset(reset), .run(run), .flush(flush), .bus(if_a), .occupancy(occ_a)
`ifdef STORE_FWD_STATS_EN
    , .stat_hits(hits_a), .stat_overwrites(ovw_a)
`endif
  );

  store_fwd_buffer #(.AW(32), .DW(32), .DEPTH(4), .LIFETIME(8)) dut_b (
    .clk(clk), .reset(reset), .run(run), .flush(flush), .bus(if_b), .occupancy(occ_b)
`ifdef STORE_FWD_STATS_EN
    , .stat_hits(hits_b), .stat_overwrites(ovw_b)
`endif
  );

  typedef struct {
    logic [31:0] d;
    logic        h;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          sel      = 1'b0;
  logic [31:0] exp_d_n, next_mem;
  logic        exp_h_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops one expectation whenever the selected DUT presents load data.
  always @(negedge clk) begin
    logic        v, h;
    logic [31:0] d;
    exp_t        e;
    v = sel ? if_b.ld_data_valid : if_a.ld_data_valid;
    d = sel ? if_b.ld_data       : if_a.ld_data;
    h = sel ? if_b.fwd_hit       : if_a.fwd_hit;
    if (v === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ld_data_valid", 64'(v), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("ld_data", 64'(d), 64'(e.d));
        check("fwd_hit", 64'(h), 64'(e.h));
      end
    end
  end

  task automatic tick();
    exp_t e;
    if (run && ld_valid && reset) begin
      e.d = exp_d_n;
      e.h = exp_h_n;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    mem_rdata = next_mem;
    next_mem  = '0;
    st_valid  = 1'b0;
    ld_valid  = 1'b0;
    flush     = 1'b0;
    run       = 1'b1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid = 1'b1;
    st_addr  = a;
    st_wdata = d;
    st_be    = be;
  endtask

  // Issue a load; nm is mem_rdata for the following cycle, ed/eh the hand-computed response.
  task automatic ld(input logic [31:0] a, input logic [31:0] nm, input logic [31:0] ed, input logic eh);
    ld_valid = 1'b1;
    ld_addr  = a;
    next_mem = nm;
    exp_d_n  = ed;
    exp_h_n  = eh;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; run = 1'b1; flush = 1'b0;
    st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_be = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_rdata = '0; next_mem = '0;
    exp_d_n = '0; exp_h_n = 1'b0;

    // Reset state: nothing valid, ld_data passes memory through.
    tick();
    next_mem = 32'hCAFE_F00D;
    tick();
    @(negedge clk);
    check("rst_occupancy_a", 64'(occ_a), 64'd0);
    check("rst_occupancy_b", 64'(occ_b), 64'd0);
    check("rst_ld_data_valid", 64'(if_a.ld_data_valid), 64'd0);
    check("rst_fwd_hit", 64'(if_a.fwd_hit), 64'd0);
    check("rst_ld_data", 64'(if_a.ld_data), 64'hCAFE_F00D);
    reset = 1'b1;

    // Full-word forward.
    st(32'h100, 32'hDEAD_BEEF, 4'hF); tick();
    ld(32'h100, 32'h0, 32'hDEAD_BEEF, 1'b1); tick();
    // Single-lane forward with offset bits ignored.
    st(32'h104, 32'h0000_AB00, 4'h2); tick();
    ld(32'h107, 32'h1122_3344, 32'h1122_AB44, 1'b1); tick();
    repeat (6) tick();

    // Youngest wins, same-cycle store bypass, per-lane merge.
    st(32'h108, 32'h1, 4'hF); tick();
    st(32'h108, 32'h2, 4'hF); tick();
    st(32'h10C, 32'h3, 4'hF); ld(32'h10C, 32'hFFFF_FFFF, 32'h3, 1'b1); tick();
    st(32'h108, 32'h0000_EE00, 4'h2); ld(32'h108, 32'hFFFF_FFFF, 32'h0000_EE02, 1'b1); tick();
    repeat (6) tick();

    // Lifetime boundary (LIFETIME 4).
    @(negedge clk);
    check("empty_before_lifetime", 64'(occ_a), 64'd0);
    st(32'h200, 32'h5566_7788, 4'hF); tick();
    tick(); tick();
    ld(32'h200, 32'h0, 32'h5566_7788, 1'b1); tick();
    ld(32'h200, 32'h1234_5678, 32'h1234_5678, 1'b0); tick();
    tick();
    @(negedge clk);
    check("empty_after_lifetime", 64'(occ_a), 64'd0);

    // Frozen ageing across run=0; stores and loads ignored while frozen.
    st(32'h200, 32'h99AA_BBCC, 4'hF); tick();
    ld(32'h200, 32'h0, 32'h99AA_BBCC, 1'b1); tick();
    run = 1'b0; st(32'h204, 32'hFFFF_FFFF, 4'hF); ld(32'h204, 32'h0, 32'h0, 1'b0); tick();
    run = 1'b0; ld(32'h200, 32'h0, 32'h0, 1'b0); tick();
    tick();
    ld(32'h200, 32'h0, 32'h99AA_BBCC, 1'b1); tick();
    ld(32'h200, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0); tick();
    ld(32'h204, 32'h0102_0304, 32'h0102_0304, 1'b0); tick();
    tick();

    // Overflow overwrites the oldest entry (dut_b, LIFETIME 8).
    do_reset();
    sel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      st(32'h300 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF);
      tick();
    end
    @(negedge clk);
    check("occupancy_full", 64'(occ_b), 64'd4);
    ld(32'h300, 32'h77, 32'h77, 1'b0); tick();
    ld(32'h310, 32'h0, 32'hA4, 1'b1); tick();
    ld(32'h304, 32'h0, 32'hA1, 1'b1); tick();
    tick(); tick();
`ifdef STORE_FWD_STATS_EN
    @(negedge clk);
    check("stat_overwrites", 64'(ovw_b), 64'd1);
    check("stat_hits", 64'(hits_b), 64'd2);
`endif

    // Flush with same-cycle store and load, then reset mid-load.
    do_reset();
    sel = 1'b0;
    st(32'h500, 32'h50, 4'hF); tick();
    st(32'h504, 32'h54, 4'hF); tick();
    st(32'h508, 32'h58, 4'hF); tick();
    @(negedge clk);
    check("occupancy_three", 64'(occ_a), 64'd3);
    flush = 1'b1; st(32'h400, 32'h44, 4'hF); ld(32'h500, 32'h9999, 32'h50, 1'b1); tick();
    @(negedge clk);
    check("occupancy_after_flush", 64'(occ_a), 64'd0);
    ld(32'h400, 32'h1357, 32'h1357, 1'b0); tick();
    ld(32'h508, 32'h2468, 32'h2468, 1'b0); tick();
    tick();
    ld(32'h400, 32'h0, 32'h0, 1'b0); reset = 1'b0; tick();
    @(negedge clk);
    check("reset_mid_load_valid", 64'(if_a.ld_data_valid), 64'd0);
    check("reset_mid_load_hit", 64'(if_a.fwd_hit), 64'd0);
    reset = 1'b1;
    tick(); tick();

    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
